// File: rtl/rpn_pkg.sv
// Shared types and constants for the RPN calculator controller.
// Operation codes, unary-code mask and controller state encoding.
package rpn_pkg;

  localparam int LARGURA_PAD = 8;

  localparam logic [2:0] OP_SOMA = 3'd0;
  localparam logic [2:0] OP_SUB  = 3'd1;
  localparam logic [2:0] OP_AND  = 3'd2;
  localparam logic [2:0] OP_OR   = 3'd3;
  localparam logic [2:0] OP_XOR  = 3'd4;
  localparam logic [2:0] OP_MUL  = 3'd5;
  localparam logic [2:0] OP_NOT  = 3'd6;
  localparam logic [2:0] OP_NEG  = 3'd7;

  localparam logic [2:0] UNARIO_MASK = 3'b110;

  typedef enum logic [2:0] {
    OCIOSO,
    PUSH_NUM,
    POP_B,
    POP_A,
    EXEC,
    ESPERA,
    PUSH_RES,
    ERRO
  } estado_t;

  function automatic logic eh_unario(input logic [2:0] op);
    return (op & UNARIO_MASK) == UNARIO_MASK;
  endfunction

endpackage

// File: rtl/controlador_rpn_debounce.sv
// Key synchronizer and debouncer; emits one pulse per accepted press.
// Keys are active-low, so the idle accepted level is 1.
module debounce_botao #(
  parameter int CICLOS = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_btn_n,
  output logic o_evento
);

  localparam int CW = $clog2(CICLOS + 1);

  logic          r_s1;
  logic          r_s2;
  logic          r_nivel;
  logic [CW-1:0] r_cnt;
  logic          r_evento;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1     <= 1'b1;
      r_s2     <= 1'b1;
      r_nivel  <= 1'b1;
      r_cnt    <= '0;
      r_evento <= 1'b0;
    end else begin
      r_s1     <= i_btn_n;
      r_s2     <= r_s1;
      r_evento <= 1'b0;
      if (r_s2 == r_nivel) begin
        r_cnt <= '0;
      end else if (r_cnt == CW'(CICLOS - 1)) begin
        // new level held for CICLOS samples in a row
        r_nivel  <= r_s2;
        r_cnt    <= '0;
        r_evento <= ~r_s2;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  assign o_evento = r_evento;

endmodule

// File: rtl/controlador_rpn.sv
// Sequencing controller between board keys, stack and ALU.
// Pushes numbers, pops operands, runs the ALU and pushes the result.
module controlador_rpn
  import rpn_pkg::*;
#(
  parameter int LARGURA         = LARGURA_PAD,
  parameter int PROFUNDIDADE    = 8,
  parameter int DEBOUNCE_CICLOS = 16,
  parameter int ULA_TIMEOUT     = 31
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              btn_numero,
  input  logic                              btn_operacao,
  input  logic [LARGURA-1:0]                entrada,
  input  logic [2:0]                        codigo_op,
  input  logic [LARGURA-1:0]                pilha_topo,
  output logic                              pilha_push,
  output logic                              pilha_pop,
  output logic [LARGURA-1:0]                pilha_dado,
  output logic [LARGURA-1:0]                ula_a,
  output logic [LARGURA-1:0]                ula_b,
  output logic [2:0]                        ula_op,
  output logic                              ula_start,
  input  logic                              ula_pronto,
  input  logic [LARGURA-1:0]                ula_resultado,
  input  logic                              ula_erro,
  output logic [$clog2(PROFUNDIDADE+1)-1:0] profundidade,
  output logic [LARGURA-1:0]                valor_exibido,
  output logic                              ocupado,
  output logic                              erro
);

  localparam int PW = $clog2(PROFUNDIDADE + 1);
  localparam int TW = $clog2(ULA_TIMEOUT + 1);

  estado_t            r_estado;
  estado_t            w_prox;
  logic [PW-1:0]      r_prof;
  logic [LARGURA-1:0] r_dado;
  logic [LARGURA-1:0] r_exib;
  logic [LARGURA-1:0] r_a;
  logic [LARGURA-1:0] r_b;
  logic [2:0]         r_op;
  logic [TW-1:0]      r_timer;

  logic          w_ev_num;
  logic          w_ev_op;
  logic          w_unario;
  logic [PW-1:0] w_min;

  debounce_botao #(.CICLOS(DEBOUNCE_CICLOS)) u_deb_num (
    .clk      (clk),
    .rst_n    (rst),
    .i_btn_n  (btn_numero),
    .o_evento (w_ev_num)
  );

  debounce_botao #(.CICLOS(DEBOUNCE_CICLOS)) u_deb_op (
    .clk      (clk),
    .rst_n    (rst),
    .i_btn_n  (btn_operacao),
    .o_evento (w_ev_op)
  );

  assign w_unario = eh_unario(codigo_op);
  assign w_min    = w_unario ? PW'(1) : PW'(2);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_estado <= OCIOSO;
    else      r_estado <= w_prox;
  end

  always_comb begin
    w_prox     = r_estado;
    pilha_push = 1'b0;
    pilha_pop  = 1'b0;
    ula_start  = 1'b0;
    ocupado    = 1'b1;
    erro       = 1'b0;
    unique case (r_estado)
      OCIOSO: begin
        ocupado = 1'b0;
        // number key has priority over a same-cycle operation key
        if (w_ev_num) begin
          if (r_prof == PW'(PROFUNDIDADE)) w_prox = ERRO;
          else                             w_prox = PUSH_NUM;
        end else if (w_ev_op) begin
          if (r_prof < w_min) w_prox = ERRO;
          else if (w_unario)  w_prox = POP_A;
          else                w_prox = POP_B;
        end
      end
      PUSH_NUM: begin
        pilha_push = 1'b1;
        w_prox     = OCIOSO;
      end
      POP_B: begin
        pilha_pop = 1'b1;
        w_prox    = POP_A;
      end
      POP_A: begin
        pilha_pop = 1'b1;
        w_prox    = EXEC;
      end
      EXEC: begin
        ula_start = 1'b1;
        w_prox    = ESPERA;
      end
      ESPERA: begin
        if (ula_pronto)                     w_prox = ula_erro ? ERRO : PUSH_RES;
        else if (r_timer == TW'(ULA_TIMEOUT)) w_prox = ERRO;
      end
      PUSH_RES: begin
        pilha_push = 1'b1;
        w_prox     = OCIOSO;
      end
      ERRO: begin
        ocupado = 1'b0;
        erro    = 1'b1;
        if (w_ev_num || w_ev_op) w_prox = OCIOSO;
      end
      default: w_prox = OCIOSO;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_prof  <= '0;
      r_dado  <= '0;
      r_exib  <= '0;
      r_a     <= '0;
      r_b     <= '0;
      r_op    <= '0;
      r_timer <= '0;
    end else begin
      unique case (r_estado)
        OCIOSO: begin
          if (w_prox == PUSH_NUM) r_dado <= entrada;
          if (w_prox == POP_B || w_prox == POP_A) r_op <= codigo_op;
          if (w_prox == POP_A) r_b <= '0;
        end
        PUSH_NUM, PUSH_RES: begin
          r_prof <= r_prof + 1'b1;
          r_exib <= r_dado;
        end
        POP_B: begin
          r_b    <= pilha_topo;
          r_prof <= r_prof - 1'b1;
        end
        POP_A: begin
          r_a    <= pilha_topo;
          r_prof <= r_prof - 1'b1;
        end
        EXEC: r_timer <= '0;
        ESPERA: begin
          r_timer <= r_timer + 1'b1;
          if (ula_pronto) r_dado <= ula_resultado;
        end
        default: ;
      endcase
    end
  end

  assign pilha_dado    = r_dado;
  assign ula_a         = r_a;
  assign ula_b         = r_b;
  assign ula_op        = r_op;
  assign profundidade  = r_prof;
  assign valor_exibido = r_exib;

endmodule
